// File: rtl/mac_pkg.sv
// Shared widths, Q8.8 limits and the accumulator-to-Q8.8 saturation helper.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package mac_pkg;

  localparam int DW    = 16;  // product / result width, Q8.8
  localparam int FRAC  = 8;   // fractional bits of Q8.8
  localparam int LANES = 64;  // lanes delivered by the multiplier array
  localparam int ACCW  = 24;  // Q16.8 accumulator, headroom for 16 full-scale terms

  localparam logic [DW-1:0] Q_MIN = 16'h8000;
  localparam logic [DW-1:0] Q_MAX = 16'h7FFF;

  // Clamp a signed Q16.8 accumulator into the Q8.8 range.
  function automatic logic [DW-1:0] sat16(input logic signed [ACCW-1:0] a);
    logic signed [ACCW-1:0] hi;
    logic signed [ACCW-1:0] lo;
    hi = {{(ACCW-DW){1'b0}}, Q_MAX};
    lo = {{(ACCW-DW){1'b1}}, Q_MIN};
    if (a > hi) begin
      sat16 = Q_MAX;
    end else if (a < lo) begin
      sat16 = Q_MIN;
    end else begin
      sat16 = a[DW-1:0];
    end
  endfunction

endpackage

// File: rtl/mac_acc_lane.sv
// One lane: sign-extend, load-or-add into the accumulator, saturate, optional ReLU, result register.
// Latency: result register updates on the edge that accepts the last beat of a group.
// Backpressure: none locally; the top only pulses ld when a beat is actually accepted.
module mac_acc_lane
  import mac_pkg::*;
#(
  parameter int DW   = mac_pkg::DW,
  parameter int ACCW = mac_pkg::ACCW,
  parameter int RELU = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld,     // beat accepted this cycle
  input  logic          first,  // accepted beat starts a new group
  input  logic          last,   // accepted beat closes the group
  input  logic [DW-1:0] prod,
  output logic [DW-1:0] res
);

  logic signed [ACCW-1:0] ext;
  logic signed [ACCW-1:0] acc_q;
  logic signed [ACCW-1:0] acc_nxt;
  logic        [DW-1:0]   sat_v;
  logic        [DW-1:0]   res_d;

  // Next accumulator value and the finished result it would produce.
  always_comb begin
    ext     = {{(ACCW-DW){prod[DW-1]}}, prod};
    // First beat overwrites so a stale or aborted group never leaks in.
    acc_nxt = first ? ext : acc_q + ext;
    sat_v   = sat16(acc_nxt);
    res_d   = sat_v;
    if (RELU != 0 && sat_v[DW-1]) begin
      res_d = '0;
    end
  end

  // Accumulator and result register; result only moves when a group completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      res   <= '0;
    end else begin
      if (ld) begin
        acc_q <= acc_nxt;
      end
      if (ld && last) begin
        res <= res_d;
      end
    end
  end

endmodule

// File: rtl/mac_acc.sv
// Per-lane accumulation of NTERMS product beats into saturated Q8.8 neuron outputs.
// Latency: out_valid rises 1 cycle after the last beat of a group is accepted.
// Backpressure: in_ready drops while a result is held and out_ready is low, or while acc_clr is high.
module mac_acc
  import mac_pkg::*;
#(
  parameter int LANES  = mac_pkg::LANES,
  parameter int DW     = mac_pkg::DW,
  parameter int ACCW   = mac_pkg::ACCW,
  parameter int NTERMS = 16,
  parameter int RELU   = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*DW-1:0]           in_prod,
  input  logic                          acc_clr,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*DW-1:0]           out_vec,
  output logic [$clog2(NTERMS+1)-1:0]   grp_cnt
);

  localparam int CW = $clog2(NTERMS+1);

  logic accept;
  logic first_beat;
  logic last_beat;

  // A held result blocks new beats only until it drains; a drain and a new
  // beat may share a cycle.
  assign in_ready   = !acc_clr && (!out_valid || out_ready);
  assign accept     = in_valid && in_ready;
  assign first_beat = (grp_cnt == '0);
  assign last_beat  = (grp_cnt == CW'(NTERMS-1));

  // Beat counter within the current group; acc_clr aborts the group.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grp_cnt <= '0;
    end else if (acc_clr) begin
      grp_cnt <= '0;
    end else if (accept) begin
      grp_cnt <= last_beat ? '0 : grp_cnt + 1'b1;
    end
  end

  // Result valid: set on group completion (wins over a same-cycle drain), cleared on drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else if (accept && last_beat) begin
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mac_acc_lane #(
      .DW   (DW),
      .ACCW (ACCW),
      .RELU (RELU)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .ld    (accept),
      .first (first_beat),
      .last  (last_beat),
      .prod  (in_prod[i*DW +: DW]),
      .res   (out_vec[i*DW +: DW])
    );
  end

endmodule

// File: tb/tb_mac_acc.sv
// Bench for mac_acc: two instances (ReLU off / on) driven with identical beats,
// a cycle model predicts handshake and grp_cnt, a scoreboard queue holds expected vectors.
module tb_mac_acc;

  localparam int L  = 64;
  localparam int W  = 16;
  localparam int NT = 4;
  localparam int CW = $clog2(NT+1);

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            acc_clr;
  logic            out_ready;
  logic [L*W-1:0]  in_prod;

  logic            in_ready_a,  in_ready_b;
  logic            out_valid_a, out_valid_b;
  logic [L*W-1:0]  out_vec_a,   out_vec_b;
  logic [CW-1:0]   grp_cnt_a,   grp_cnt_b;

  int checks = 0;
  int errors = 0;

  // model state
  logic            mdl_en = 1'b0;
  int              m_cnt  = 0;
  logic            m_ov   = 1'b0;
  int              m_acc [L];
  logic [L*W-1:0]  q_a [$];
  logic [L*W-1:0]  q_b [$];

  always #5 clk = ~clk;

  mac_acc #(.LANES(L), .DW(W), .ACCW(24), .NTERMS(NT), .RELU(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_prod(in_prod), .acc_clr(acc_clr), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_vec(out_vec_a), .grp_cnt(grp_cnt_a));

  mac_acc #(.LANES(L), .DW(W), .ACCW(24), .NTERMS(NT), .RELU(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_prod(in_prod), .acc_clr(acc_clr), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_vec(out_vec_b), .grp_cnt(grp_cnt_b));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Independent Q8.8 saturation + optional ReLU of an unbounded integer sum.
  function automatic logic [15:0] ref_sat(input int v, input bit relu);
    int s;
    s = v;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    if (relu && s < 0) s = 0;
    return s[15:0];
  endfunction

  // Cycle model: checks visible state before each edge, then advances as the edge will.
  always @(negedge clk) begin
    if (rst_n && mdl_en) begin
      logic exp_rdy;
      logic done;
      logic [L*W-1:0] e_a;
      logic [L*W-1:0] e_b;
      done    = 1'b0;
      exp_rdy = !acc_clr && (!m_ov || out_ready);
      chk("in_ready_a",  {63'd0, in_ready_a},  {63'd0, exp_rdy});
      chk("in_ready_b",  {63'd0, in_ready_b},  {63'd0, exp_rdy});
      chk("out_valid_a", {63'd0, out_valid_a}, {63'd0, m_ov});
      chk("out_valid_b", {63'd0, out_valid_b}, {63'd0, m_ov});
      chk("grp_cnt_a",   64'(grp_cnt_a),       64'(m_cnt));
      chk("grp_cnt_b",   64'(grp_cnt_b),       64'(m_cnt));
      if (m_ov) begin
        chk("sb_pending", 64'(q_a.size()), 64'd1);
        if (q_a.size() != 0) begin
          for (int i = 0; i < L; i++) begin
            chk($sformatf("vec_a_lane%0d", i), 64'(out_vec_a[i*W +: W]), 64'(q_a[0][i*W +: W]));
            chk($sformatf("vec_b_lane%0d", i), 64'(out_vec_b[i*W +: W]), 64'(q_b[0][i*W +: W]));
          end
          if (out_ready) begin
            void'(q_a.pop_front());
            void'(q_b.pop_front());
          end
        end
      end
      if (in_valid && exp_rdy) begin
        for (int i = 0; i < L; i++) begin
          int p;
          p = int'($signed(in_prod[i*W +: W]));
          m_acc[i] = (m_cnt == 0) ? p : m_acc[i] + p;
        end
        if (m_cnt == NT-1) begin
          for (int i = 0; i < L; i++) begin
            e_a[i*W +: W] = ref_sat(m_acc[i], 1'b0);
            e_b[i*W +: W] = ref_sat(m_acc[i], 1'b1);
          end
          q_a.push_back(e_a);
          q_b.push_back(e_b);
          m_cnt = 0;
          done  = 1'b1;
        end else begin
          m_cnt++;
        end
      end
      if (acc_clr) m_cnt = 0;
      if (done) m_ov = 1'b1;
      else if (m_ov && out_ready) m_ov = 1'b0;
    end
  end

  // Present one cycle of inputs: every lane = v.
  task automatic drive(input logic [15:0] v, input logic vld);
    in_valid = vld;
    for (int i = 0; i < L; i++) in_prod[i*W +: W] = v;
    @(posedge clk); #1;
  endtask

  // Lane i = i*k.
  task automatic drive_idx(input int k);
    in_valid = 1'b1;
    for (int i = 0; i < L; i++) in_prod[i*W +: W] = 16'(i*k);
    @(posedge clk); #1;
  endtask

  // Lane0 / lane1 / rest get distinct values.
  task automatic drive3(input logic [15:0] v0, input logic [15:0] v1, input logic [15:0] vr);
    in_valid = 1'b1;
    for (int i = 0; i < L; i++) in_prod[i*W +: W] = vr;
    in_prod[0 +: W] = v0;
    in_prod[W +: W] = v1;
    @(posedge clk); #1;
  endtask

  // Asynchronous reset pulse between edges; outputs must clear without a clock.
  task automatic rst_pulse(input string tag);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk({tag, "_out_valid"}, {63'd0, out_valid_a}, 64'd0);
    chk({tag, "_grp_cnt"},   64'(grp_cnt_a),       64'd0);
    chk({tag, "_in_ready"},  {63'd0, in_ready_a},  64'd1);
    chk({tag, "_vec_a"},     64'(out_vec_a == '0), 64'd1);
    chk({tag, "_vec_b"},     64'(out_vec_b == '0), 64'd1);
    m_cnt = 0;
    m_ov  = 1'b0;
    q_a.delete();
    q_b.delete();
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    acc_clr   = 1'b0;
    out_ready = 1'b1;
    in_prod   = '0;
    for (int i = 0; i < L; i++) m_acc[i] = 0;
    #2;
    chk("rst_out_valid", {63'd0, out_valid_a}, 64'd0);
    chk("rst_grp_cnt",   64'(grp_cnt_a),       64'd0);
    chk("rst_in_ready",  {63'd0, in_ready_a},  64'd1);
    chk("rst_vec",       64'(out_vec_a == '0), 64'd1);
    #10;
    rst_n = 1'b1;
    @(posedge clk); #1;
    mdl_en = 1'b1;

    // 1: uniform 1.0 x4 -> 4.0
    repeat (NT) drive(16'h0100, 1'b1);
    drive(16'h0000, 1'b0);
    drive(16'h0000, 1'b0);

    // 2: lane index pattern, result valid for a single cycle
    repeat (NT) drive_idx(1);
    repeat (3) drive(16'h0000, 1'b0);

    // 3: saturation both directions, negative non-saturating lanes
    repeat (NT) drive3(16'h7F00, 16'h8000, 16'hFF00);
    repeat (2) drive(16'h0000, 1'b0);

    // 4: backpressure, then drain + beat-1 load in one cycle
    repeat (NT) drive(16'h0200, 1'b1);
    out_ready = 1'b0;
    repeat (5) drive(16'h0010, 1'b1);
    out_ready = 1'b1;
    repeat (NT) drive(16'h0010, 1'b1);
    repeat (2) drive(16'h0000, 1'b0);

    // 5: abort after 2 beats with a beat offered during acc_clr
    repeat (2) drive(16'h0100, 1'b1);
    acc_clr = 1'b1;
    drive(16'h0100, 1'b1);
    acc_clr = 1'b0;
    repeat (NT) drive(16'h0100, 1'b1);
    repeat (2) drive(16'h0000, 1'b0);

    // 6a: reset while a result is held
    repeat (NT) drive(16'h0300, 1'b1);
    out_ready = 1'b0;
    drive(16'h0000, 1'b0);
    rst_pulse("rst_hold");
    out_ready = 1'b1;
    // 6b: reset mid-group, then a fresh group
    repeat (2) drive(16'h0100, 1'b1);
    rst_pulse("rst_mid");
    repeat (NT) drive(16'h0200, 1'b1);
    repeat (3) drive(16'h0000, 1'b0);

    // 7: randomised groups with random backpressure and aborts
    for (int n = 0; n < 200; n++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 3) != 0);
      acc_clr   = 1'($urandom_range(0, 19) == 0);
      for (int i = 0; i < L; i++) in_prod[i*W +: W] = 16'($urandom);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    acc_clr   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 64'(q_a.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
